program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 Ports SHALL be:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous active-low reset
- START  input  1  one-cycle pulse that begins a load
- BYTE_IN  input  8  received stream byte
- BYTE_VALID  input  1  BYTE_IN valid
- BYTE_READY  output  1  loader accepts a byte
- MEM_WE  output  1  instruction-memory write strobe
- MEM_ADDR  output  10  instruction-memory write address
- MEM_WDATA  output  10  instruction word
- CPU_HOLD  output  1  holds the processor in reset
- DONE  output  1  load finished successfully (sticky)
- ERROR  output  1  load aborted (sticky)
- WORD_COUNT  output  10  words written so far

Function
REQ-003 A byte SHALL be accepted on a rising CLK edge only when BYTE_VALID and BYTE_READY are both 1.
REQ-004 BYTE_READY SHALL be 1 in states HDR, LEN_HI, LEN_LO, DATA_LO, DATA_HI and CHK, and 0 in all other states.
REQ-005 States and transitions SHALL be:
- IDLE, DONE_S, ERR_S: START → HDR.
- HDR: 0xA5 → LEN_HI; any other byte → ERR_S.
- LEN_HI: bits[1:0] → N[9:8]; bits[7:2] nonzero → ERR_S; otherwise → LEN_LO.
- LEN_LO: byte → N[7:0]; N==0 → ERR_S; otherwise → DATA_LO.
REQ-006 In DATA_LO, the accepted byte SHALL be latched as word[7:0], then → DATA_HI.
REQ-007 In DATA_HI, bits[7:2] nonzero → ERR_S; otherwise bits[1:0] → word[9:8].
REQ-008 After an accepted DATA_HI byte, MEM_WE SHALL be 1 for exactly the next cycle, with MEM_ADDR = current word index and MEM_WDATA = assembled word.
REQ-009 MEM_ADDR SHALL start at 0 and increment by 1 after each write; WORD_COUNT SHALL equal the number of completed writes.
REQ-010 After the write of word index N-1, the next state SHALL be CHK (checksum build) or DONE_S (no checksum); otherwise it SHALL be DATA_LO.
REQ-011 N==1023 SHALL write addresses 0..1022; the address SHALL never wrap within a load.
REQ-012 CPU_HOLD SHALL rise in the cycle after START and stay 1 in all states except IDLE, DONE_S and ERR_S.
REQ-013 DONE and ERROR SHALL be mutually exclusive, SHALL hold until the next START, and SHALL clear in the cycle after START.
REQ-014 START SHALL be ignored in states HDR through CHK.
REQ-015 A BYTE_VALID with no byte accepted SHALL change no state.
REQ-016 On a transition to ERR_S, MEM_WE SHALL stay 0 and memory already written SHALL not be reverted.

Reset
REQ-017 Reset assertion SHALL immediately force state IDLE, BYTE_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CPU_HOLD=0, DONE=0, ERROR=0, WORD_COUNT=0; this applies mid-load, and any partial word SHALL be discarded.
REQ-018 Operation SHALL resume on the first rising CLK edge after RESET_N deasserts.

Configuration
REQ-019 With LOADER_CHECKSUM_EN defined:
- A running 8-bit XOR of all DATA_LO and DATA_HI bytes SHALL be kept, cleared on START.
- In CHK, a byte equal to the XOR → DONE_S; otherwise → ERR_S.
REQ-020 Without LOADER_CHECKSUM_EN, the CHK state and XOR register SHALL not exist, and the last write SHALL go directly to DONE_S.

Structure
REQ-021 A shared package SHALL hold the state enumeration, the header constant 0xA5, and the 10-bit word/address width constants.
REQ-022 The block SHALL be a single module with no sub-modules; the FSM and datapath SHALL be flat.

Verification
REQ-023 The bench SHALL cover these scenarios:
- START; bytes A5,00,02,3C,01,FF,02, checksum 0x3C^0x01^0xFF^0x02=0xC0 → writes addr0=0x13C and addr1=0x2FF, then DONE=1, CPU_HOLD=0, WORD_COUNT=2.
- START; header byte 0x5A → ERROR=1, no MEM_WE, CPU_HOLD=0.
- START; A5,00,01,10,04 → ERROR=1 after the DATA_HI byte, no write.
- A load with BYTE_VALID toggling every other cycle → same writes as the back-to-back case, each MEM_WE exactly one cycle.
- RESET_N pulsed low after one word of a 3-word load → all outputs 0 in the same cycle; a fresh START then loads from addr0.
- With the checksum built, a wrong checksum byte 0x00 → ERROR=1 and WORD_COUNT=N.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg -- shared definitions for the program loader.
//   state_e   : loader FSM states (S_CHK exists only with LOADER_CHECKSUM_EN)
//   HDR_BYTE  : stream header constant
//   WORD_W    : instruction word width
//   ADDR_W    : instruction memory address / word counter width
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
package program_loader_pkg;

    localparam int         WORD_W   = 10;
    localparam int         ADDR_W   = 10;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_LO,
        S_DATA_HI,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/program_loader.sv
// program_loader -- receives a byte stream (header, 10-bit length, 10-bit
// words as lo/hi byte pairs, optional XOR checksum) and writes the words into
// instruction memory while holding the CPU in reset.
// Ports:
//   CLK, RESET_N             clock, async active-low reset
//   START                    one-cycle pulse, begins a load from IDLE/DONE/ERR
//   BYTE_IN/BYTE_VALID       stream byte input, accepted with BYTE_READY
//   BYTE_READY               loader can accept a byte this cycle
//   MEM_WE/MEM_ADDR/MEM_WDATA one-cycle instruction memory write
//   CPU_HOLD                 high while a load is in progress
//   DONE / ERROR             sticky completion / abort flags
//   WORD_COUNT               number of words written in this load
// Optional feature macro: LOADER_CHECKSUM_EN -- adds the CHK state and the
// running XOR of all data bytes; without it the last write ends the load.
module program_loader
    import program_loader_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [WORD_W-1:0] MEM_WDATA,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERROR,
    output logic [ADDR_W-1:0] WORD_COUNT
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;      // N, words in this load
    logic [ADDR_W-1:0] idx_q, idx_d;      // current word index == completed writes
    logic [7:0]        lo_q, lo_d;        // low byte of the word being assembled
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic accept;
    assign accept = BYTE_VALID & ready_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (START) begin
                    state_d = S_HDR;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_HDR: if (accept) state_d = (BYTE_IN == HDR_BYTE) ? S_LEN_HI : S_ERR;
            S_LEN_HI: if (accept) begin
                len_d[9:8] = BYTE_IN[1:0];
                state_d    = (BYTE_IN[7:2] != '0) ? S_ERR : S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                len_d[7:0] = BYTE_IN;
                state_d    = ({len_q[9:8], BYTE_IN} == '0) ? S_ERR : S_DATA_LO;
            end
            S_DATA_LO: if (accept) begin
                lo_d    = BYTE_IN;
`ifdef LOADER_CHECKSUM_EN
                xor_d   = xor_q ^ BYTE_IN;
`endif
                state_d = S_DATA_HI;
            end
            S_DATA_HI: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                xor_d = xor_q ^ BYTE_IN;
`endif
                if (BYTE_IN[7:2] != '0) begin
                    state_d = S_ERR;
                end else begin
                    wdata_d = {BYTE_IN[1:0], lo_q};
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end
            end
            // MEM_WE is high during this state; the index advances as it ends
            S_WRITE: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == len_q - ADDR_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA_LO;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (accept) state_d = (BYTE_IN == xor_q) ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it
        case (state_d)
            S_HDR, S_LEN_HI, S_LEN_LO, S_DATA_LO, S_DATA_HI: ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK: ready_d = 1'b1;
`endif
            default: ready_d = 1'b0;
        endcase
        hold_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign BYTE_READY = ready_q;
    assign MEM_WE     = we_q;
    assign MEM_ADDR   = idx_q;
    assign MEM_WDATA  = wdata_q;
    assign CPU_HOLD   = hold_q;
    assign DONE       = done_q;
    assign ERROR      = err_q;
    assign WORD_COUNT = idx_q;

endmodule
